// File: rtl/cmp_nic.sv
// Memory-mapped NIC bridging processor loads/stores to a ring router's local port.
// Optional NIC_IRQ_EN adds a registered nic_irq output raised while a packet waits.
module cmp_nic #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              nicEn,
   input  logic              nicWrEn,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do
`ifdef NIC_IRQ_EN
   ,
   output logic              nic_irq
`endif
);

   localparam logic [1:0] A_IN_BUF   = 2'b00;
   localparam logic [1:0] A_IN_STAT  = 2'b01;
   localparam logic [1:0] A_OUT_BUF  = 2'b10;
   localparam logic [1:0] A_OUT_STAT = 2'b11;

   logic [DATA_W-1:0] in_buf_q, in_buf_d;
   logic [DATA_W-1:0] out_buf_q, out_buf_d;
   logic [DATA_W-1:0] d_out_q, d_out_d;
   logic              in_stat_q, in_stat_d;
   logic              out_stat_q, out_stat_d;

   assign net_ri = ~in_stat_q;
   assign net_so = out_stat_q;
   assign net_do = out_buf_q;
   assign d_out  = d_out_q;

   always_comb begin
      in_buf_d   = in_buf_q;
      in_stat_d  = in_stat_q;
      out_buf_d  = out_buf_q;
      out_stat_d = out_stat_q;
      d_out_d    = d_out_q;

      if (net_si && !in_stat_q) begin
         in_buf_d  = net_di;
         in_stat_d = 1'b1;
      end

      if (out_stat_q && net_ro)
         out_stat_d = 1'b0;

      // Status flags are sampled pre-edge, so a pop never races a router push
      // and a store never lands in a slot that is draining this cycle.
      if (nicEn && !nicWrEn) begin
         case (addr)
            A_IN_BUF: begin
               d_out_d = in_buf_q;
               if (in_stat_q)
                  in_stat_d = 1'b0;
            end
            A_IN_STAT:  d_out_d = {{(DATA_W-1){1'b0}}, in_stat_q};
            A_OUT_STAT: d_out_d = {{(DATA_W-1){1'b0}}, out_stat_q};
            default:    d_out_d = '0;
         endcase
      end

      if (nicEn && nicWrEn && (addr == A_OUT_BUF) && !out_stat_q) begin
         out_buf_d  = d_in;
         out_stat_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_buf_q   <= '0;
         in_stat_q  <= 1'b0;
         out_buf_q  <= '0;
         out_stat_q <= 1'b0;
         d_out_q    <= '0;
      end else begin
         in_buf_q   <= in_buf_d;
         in_stat_q  <= in_stat_d;
         out_buf_q  <= out_buf_d;
         out_stat_q <= out_stat_d;
         d_out_q    <= d_out_d;
      end
   end

`ifdef NIC_IRQ_EN
   // Trails in_stat by one cycle: set after arrival, clear after the pop.
   logic irq_q;
   assign nic_irq = irq_q;

   always_ff @(posedge clk) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= in_stat_q;
   end
`endif

endmodule

// File: tb/tb_cmp_nic.sv
// Directed self-checking bench for cmp_nic (default build; NIC_IRQ_EN adds irq checks).
module tb_cmp_nic;

   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        addr;
   logic [DATA_W-1:0] d_in;
   logic [DATA_W-1:0] d_out;
   logic              nicEn;
   logic              nicWrEn;
   logic              net_si;
   logic              net_ri;
   logic [DATA_W-1:0] net_di;
   logic              net_so;
   logic              net_ro;
   logic [DATA_W-1:0] net_do;
`ifdef NIC_IRQ_EN
   logic              nic_irq;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cmp_nic #(.DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do)
`ifdef NIC_IRQ_EN
      , .nic_irq(nic_irq)
`endif
   );

   // Inputs change 1 time unit after an edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      nicEn = 0; nicWrEn = 0; addr = 2'b00; d_in = '0;
      net_si = 0; net_di = '0; net_ro = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      step(); step();
      reset = 0;
      tests++; if (net_ri !== 1'b1) begin fails++; $display("FAIL reset_net_ri got %0b exp 1", net_ri); end
      tests++; if (net_so !== 1'b0) begin fails++; $display("FAIL reset_net_so got %0b exp 0", net_so); end
      tests++; if (net_do !== 64'h0) begin fails++; $display("FAIL reset_net_do got %h exp 0", net_do); end
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL reset_d_out got %h exp 0", d_out); end
      step();
      tests++; if (net_ri !== 1'b1 || net_so !== 1'b0) begin fails++; $display("FAIL idle_flags got ri=%0b so=%0b exp 1/0", net_ri, net_so); end
   endtask

   task automatic test_router_rx();
      net_si = 1; net_di = 64'hDEAD_BEEF_0000_0001;
      step();
      net_si = 0; net_di = '0;
      tests++; if (net_ri !== 1'b0) begin fails++; $display("FAIL rx_net_ri got %0b exp 0", net_ri); end
      nicEn = 1; addr = 2'b01;
      step();
      tests++; if (d_out !== 64'h1) begin fails++; $display("FAIL rx_stat got %h exp 1", d_out); end
`ifdef NIC_IRQ_EN
      tests++; if (nic_irq !== 1'b1) begin fails++; $display("FAIL irq_set got %0b exp 1", nic_irq); end
`endif
      addr = 2'b00;
      step();
      tests++; if (d_out !== 64'hDEAD_BEEF_0000_0001) begin fails++; $display("FAIL rx_data got %h exp deadbeef00000001", d_out); end
      tests++; if (net_ri !== 1'b1) begin fails++; $display("FAIL rx_ri_after_pop got %0b exp 1", net_ri); end
      addr = 2'b01;
      step();
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL rx_stat_cleared got %h exp 0", d_out); end
`ifdef NIC_IRQ_EN
      tests++; if (nic_irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %0b exp 0", nic_irq); end
`endif
      idle();
   endtask

   task automatic test_proc_tx();
      nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'h0123_4567_89AB_CDEF;
      step();
      tests++; if (net_so !== 1'b1) begin fails++; $display("FAIL tx_so got %0b exp 1", net_so); end
      tests++; if (net_do !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL tx_do got %h exp 0123456789abcdef", net_do); end
      d_in = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      tests++; if (net_do !== 64'h0123_4567_89AB_CDEF || net_so !== 1'b1) begin fails++; $display("FAIL tx_drop got do=%h so=%0b exp 0123456789abcdef/1", net_do, net_so); end
      nicEn = 0; nicWrEn = 0; net_ro = 1;
      step();
      net_ro = 0;
      tests++; if (net_so !== 1'b0) begin fails++; $display("FAIL tx_drain_so got %0b exp 0", net_so); end
      tests++; if (net_do !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL tx_buf_kept got %h exp 0123456789abcdef", net_do); end
      nicEn = 1; addr = 2'b11;
      step();
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL tx_stat got %h exp 0", d_out); end
      addr = 2'b10;
      step();
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL read_addr10 got %h exp 0", d_out); end
      idle();
   endtask

   task automatic test_write_drain_collision();
      nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'hAAAA_0000_0000_0001;
      step();
      d_in = 64'hBBBB_0000_0000_0002; net_ro = 1;
      step();
      net_ro = 0; idle();
      tests++; if (net_so !== 1'b0 || net_do !== 64'hAAAA_0000_0000_0001) begin fails++; $display("FAIL collide got so=%0b do=%h exp 0/aaaa000000000001", net_so, net_do); end
      nicEn = 1; addr = 2'b11;
      step();
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL collide_stat got %h exp 0", d_out); end
      idle();
   endtask

   task automatic test_backpressure();
      net_si = 1; net_di = 64'd1;
      step();
      net_di = 64'd2;
      tests++; if (net_ri !== 1'b0) begin fails++; $display("FAIL bp_ri got %0b exp 0", net_ri); end
      step();
      net_di = 64'd3;
      step();
      net_si = 0; net_di = '0;
      nicEn = 1; addr = 2'b00;
      step();
      tests++; if (d_out !== 64'd1) begin fails++; $display("FAIL bp_data got %h exp 1", d_out); end
      // Pop with empty buffer returns stale data while a new router push lands.
      net_si = 1; net_di = 64'd5;
      step();
      net_si = 0; net_di = '0;
      tests++; if (d_out !== 64'd1) begin fails++; $display("FAIL stale_data got %h exp 1", d_out); end
      tests++; if (net_ri !== 1'b0) begin fails++; $display("FAIL push_during_stale got ri=%0b exp 0", net_ri); end
      step();
      tests++; if (d_out !== 64'd5 || net_ri !== 1'b1) begin fails++; $display("FAIL pop_new got d=%h ri=%0b exp 5/1", d_out, net_ri); end
      nicEn = 0;
      step();
      tests++; if (d_out !== 64'd5) begin fails++; $display("FAIL dout_hold got %h exp 5", d_out); end
      nicEn = 1; nicWrEn = 1; addr = 2'b01; d_in = 64'h1;
      step();
      nicWrEn = 0;
      tests++; if (net_ri !== 1'b1 || d_out !== 64'd5) begin fails++; $display("FAIL stat_not_writable got ri=%0b d=%h exp 1/5", net_ri, d_out); end
      idle();
   endtask

   task automatic test_reset_mid();
      net_si = 1; net_di = 64'h77;
      nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'h88;
      step();
      idle();
      tests++; if (net_ri !== 1'b0 || net_so !== 1'b1) begin fails++; $display("FAIL mid_setup got ri=%0b so=%0b exp 0/1", net_ri, net_so); end
      reset = 1; net_si = 1; net_di = 64'h99;
      step();
      reset = 0; idle();
      tests++; if (net_ri !== 1'b1 || net_so !== 1'b0) begin fails++; $display("FAIL mid_flags got ri=%0b so=%0b exp 1/0", net_ri, net_so); end
      tests++; if (net_do !== 64'h0 || d_out !== 64'h0) begin fails++; $display("FAIL mid_data got do=%h d=%h exp 0/0", net_do, d_out); end
      nicEn = 1; addr = 2'b01;
      step();
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL mid_in_stat got %h exp 0", d_out); end
      addr = 2'b11;
      step();
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL mid_out_stat got %h exp 0", d_out); end
      addr = 2'b00;
      step();
      tests++; if (d_out !== 64'h0) begin fails++; $display("FAIL mid_in_buf got %h exp 0", d_out); end
      idle();
   endtask

   initial begin
      test_reset();
      test_router_rx();
      test_proc_tx();
      test_write_drain_collision();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cmp_nic.md
Name: cmp_nic

Overview:
Memory-mapped network interface that responds to processor loads/stores steered to NIC space, i.e. address bits 16 and 17 both set. It bridges the processor to the ring router through one single-entry input channel buffer and one single-entry output channel buffer, each with a status flag. It sits between the core's EX/MEM stage and the router's local port.

Parameters:
DATA_W, 64, width of processor data and network packet.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous active-high reset.
addr  in  2  register select, driven from EXMEM_imm_addr[30:31] (bit 30 is the MSB of the select). 00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status.
d_in  in  DATA_W  store data from processor.
d_out  out  DATA_W  load data to processor.
nicEn  in  1  access enable (memEn_nic).
nicWrEn  in  1  write enable (wrEn_nic); only meaningful when nicEn=1.
net_si  in  1  router to NIC: packet valid.
net_ri  out  1  NIC to router: input buffer can accept.
net_di  in  DATA_W  router to NIC packet.
net_so  out  1  NIC to router: output packet valid.
net_ro  in  1  router to NIC: ready to take output packet.
net_do  out  DATA_W  NIC to router packet.

Behaviour:
- Reset (synchronous, active-high, every clk edge it is high): in_buf=0, in_stat=0, out_buf=0, out_stat=0, d_out=0.
- After reset: net_ri=1, net_so=0, net_do=0.
- Combinational outputs: net_ri = ~in_stat; net_so = out_stat; net_do = out_buf.
- Router to NIC: on a clk edge with net_si=1 and net_ri=1, in_buf<=net_di and in_stat<=1. While in_stat=1, net_si is ignored.
- NIC to router: on a clk edge with net_so=1 and net_ro=1, out_stat<=0. out_buf keeps its value.
- Processor reads (nicEn=1, nicWrEn=0):
  - d_out is registered with 1-cycle latency, matching dmem read timing.
  - addr 00: d_out<=in_buf. If in_stat=1, also in_stat<=0 at the same edge.
  - addr 01: d_out<={DATA_W-1 zeros, in_stat}.
  - addr 11: d_out<={DATA_W-1 zeros, out_stat}.
  - addr 10: d_out<=0.
  - With no read in a cycle, d_out holds its previous value.
- Processor writes (nicEn=1, nicWrEn=1):
  - addr 10 with out_stat=0: out_buf<=d_in and out_stat<=1.
  - addr 10 with out_stat=1: write dropped, nothing changes. Software polls addr 11 first.
  - Writes to 00, 01 and 11 are ignored; status flags are not software-writable.
- Simultaneous events:
  - Read of addr 00 while in_stat=1: net_ri=0 that cycle, so no router write can collide. net_ri rises the next cycle.
  - Write of addr 10 in the same cycle as a drain (out_stat=1, net_ro=1): write dropped because status is sampled before the edge. The drain completes.
  - Read of addr 00 with in_stat=0: returns stale in_buf; in_stat stays 0.
- nicEn=0: no register changes from the processor side. Router-side handshakes continue independently.
- Reset mid-transfer: both pending packets are discarded and the flags cleared in the same edge; a router write in that cycle is not captured.

Optional Feature:
NIC_IRQ_EN:
- Defined: adds output port nic_irq (1 bit), registered, reset 0.
  - Goes to 1 the cycle after in_stat transitions 0 to 1.
  - Clears to 0 the cycle after the addr 00 read that clears in_stat.
- Undefined: port absent, no extra logic; software polls addr 01.

Test Plan:
- Reset, then idle: net_ri=1, net_so=0, net_do=0, d_out=0.
- Router handshake: net_si=1, net_di=64'hDEAD_BEEF_0000_0001 for one cycle -> next cycle net_ri=0.
  - Read addr 01 -> d_out=1 one cycle later.
  - Read addr 00 -> d_out=64'hDEAD_BEEF_0000_0001 one cycle later.
  - After that read: net_ri=1; re-read addr 01 -> 0.
- Processor write addr 10, d_in=64'h0123_4567_89AB_CDEF, net_ro=0 -> net_so=1, net_do=64'h0123_4567_89AB_CDEF, held.
  - Second write of 64'hFFFF... -> dropped; net_do unchanged.
  - Raise net_ro for one cycle -> net_so=0; read addr 11 -> 0.
- Input backpressure: hold net_si=1 for 3 cycles with values 1, 2, 3 -> in_buf=1; values 2 and 3 rejected (net_ri=0).
- Reset asserted while in_stat=1 and out_stat=1 -> next cycle net_ri=1, net_so=0, both status reads return 0.
- With NIC_IRQ_EN: router delivers a packet -> nic_irq=1 one cycle after in_stat rises; read addr 00 -> nic_irq=0 on the following cycle.
